xcache_bank_port_arb: RTL

//  Round-robin arbiter that shares one single-port xcache bank (or partition port) among

---
 rtl/xcache_bank_port_arb.sv | 123 ++++++++++++
 1 files changed

// File: rtl/xcache_bank_port_arb.sv
// rtl/xcache_bank_port_arb.sv - round-robin arbiter sharing one xcache bank port among CORES requesters
// Optional XCACHE_ARB_LOCK_EN adds core_lock and a LOCKED state for atomic read-modify-write.
module xcache_bank_port_arb #(
    parameter int CORES  = 4,
    parameter int AW     = 29,
    parameter int DW     = 32,
    parameter int RD_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CORES-1:0]      core_req,
    input  logic [CORES-1:0]      core_we,
    input  logic [CORES*AW-1:0]   core_addr,
    input  logic [CORES*DW-1:0]   core_wdata,
    input  logic [CORES*DW/8-1:0] core_be,
`ifdef XCACHE_ARB_LOCK_EN
    input  logic [CORES-1:0]      core_lock,
`endif
    output logic [CORES-1:0]      core_gnt,
    output logic [CORES-1:0]      core_rvalid,
    output logic [DW-1:0]         core_rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [AW-1:0]         mem_addr,
    output logic [DW-1:0]         mem_wdata,
    output logic [DW/8-1:0]       mem_be,
    input  logic [DW-1:0]         mem_rdata,
    output logic                  busy
);

    localparam int BW = DW / 8;
    localparam int PW = (CORES > 1) ? $clog2(CORES) : 1;

    localparam logic [0:0] ST_ARB    = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    logic [0:0]       state;
    logic [PW-1:0]    rr_ptr;
    logic [CORES-1:0] elig;
    logic             gnt_any;
    logic [PW-1:0]    gnt_idx;
    logic [PW-1:0]    nxt_ptr;
    logic [CORES-1:0] gnt_vec;

    logic [RD_LAT:0]  vld;
    logic [PW-1:0]    rid [RD_LAT:0];

`ifdef XCACHE_ARB_LOCK_EN
    logic [PW-1:0]    owner;
`endif

    // While locked only the owner is eligible; otherwise every requester is.
    always_comb begin
        elig = core_req;
`ifdef XCACHE_ARB_LOCK_EN
        if (state == ST_LOCKED) begin
            elig        = '0;
            elig[owner] = core_req[owner];
        end
`endif
    end

    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int i = 0; i < CORES; i++) begin
            int c;
            c = int'(rr_ptr) + i;
            if (c >= CORES) c = c - CORES;
            if (!gnt_any && elig[c]) begin
                gnt_any = 1'b1;
                gnt_idx = PW'(c);
            end
        end
    end

    always_comb begin
        gnt_vec          = '0;
        gnt_vec[gnt_idx] = gnt_any;
        nxt_ptr          = (int'(gnt_idx) == CORES - 1) ? '0 : gnt_idx + 1'b1;
    end

    assign core_gnt = rst ? '0 : gnt_vec;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_ARB;
            rr_ptr    <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
            vld       <= '0;
            for (int i = 0; i <= RD_LAT; i++) rid[i] <= '0;
`ifdef XCACHE_ARB_LOCK_EN
            owner     <= '0;
`endif
        end else begin
            mem_en <= gnt_any;
            if (gnt_any) begin
                mem_we    <= core_we[gnt_idx];
                mem_addr  <= core_addr[int'(gnt_idx)*AW +: AW];
                mem_wdata <= core_wdata[int'(gnt_idx)*DW +: DW];
                mem_be    <= core_be[int'(gnt_idx)*BW +: BW];
                rr_ptr    <= nxt_ptr;
`ifdef XCACHE_ARB_LOCK_EN
                owner     <= gnt_idx;
                state     <= core_lock[gnt_idx] ? ST_LOCKED : ST_ARB;
`endif
            end
            // Owner pipe: stage RD_LAT lines up with mem_rdata for that read.
            vld    <= {vld[RD_LAT-1:0], gnt_any & ~core_we[gnt_idx]};
            rid[0] <= gnt_idx;
            for (int i = 1; i <= RD_LAT; i++) rid[i] <= rid[i-1];
        end
    end

    assign core_rvalid = vld[RD_LAT] ? (CORES'(1) << rid[RD_LAT]) : '0;
    assign core_rdata  = vld[RD_LAT] ? mem_rdata : '0;
    assign busy        = (|vld) || (state == ST_LOCKED);

endmodule
